// File: rtl/fft_out_streamer.sv
// Captures a parallel FFT result frame and streams it out one bin per valid/ready beat.
// Optional build macro FFT_STREAM_SCALE_EN: emitted bins are rounded and divided by N.
module fft_out_streamer #(
  parameter int DW   = 16,
  parameter int NMAX = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           fft_select_i,
  input  logic                 fft_valid_i,
  input  logic [NMAX*DW-1:0]   X_R_i,
  input  logic [NMAX*DW-1:0]   X_I_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DW-1:0]        m_R_o,
  output logic [DW-1:0]        m_I_o,
  output logic [4:0]           m_index_o,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t              state_r, next_s;
  logic [NMAX*DW-1:0]  cap_re_r, cap_im_r;
  logic [1:0]          sel_r;
  logic [4:0]          index_r;
  logic                overrun_r;
  logic                capture_s, adv_s, drop_s, hs_s, last_s;
  logic [5:0]          n_s;
  logic [DW-1:0]       raw_re_s, raw_im_s;

`ifdef FFT_STREAM_SCALE_EN
  // Round half up, then divide by N = 2^(sel+2) with an arithmetic shift at DW+1 bits.
  function automatic logic [DW-1:0] scale_fn(input logic [DW-1:0] x, input logic [1:0] sel);
    logic signed [DW:0] ext_v, rnd_v, sum_v, one_v;
    logic [2:0]         sh_v;
    sh_v  = {1'b0, sel} + 3'd2;
    one_v = {{DW{1'b0}}, 1'b1};
    rnd_v = one_v << (sh_v - 3'd1);
    ext_v = {x[DW-1], x};
    sum_v = ext_v + rnd_v;
    sum_v = sum_v >>> sh_v;
    return sum_v[DW-1:0];
  endfunction
`endif

  assign n_s    = 6'd4 << sel_r;
  assign last_s = ({1'b0, index_r} == (n_s - 6'd1));
  assign hs_s   = (state_r == STREAM) && m_ready_i;

  // Next-state and datapath control decode.
  always_comb begin
    next_s    = state_r;
    capture_s = 1'b0;
    adv_s     = 1'b0;
    drop_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fft_valid_i) begin
          capture_s = 1'b1;
          next_s    = STREAM;
        end else begin
          next_s    = IDLE;
        end
      end
      STREAM: begin
        if (hs_s && last_s) begin
          if (fft_valid_i) begin
            capture_s = 1'b1;
            next_s    = STREAM;
          end else begin
            next_s    = IDLE;
          end
        end else if (hs_s) begin
          adv_s = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
        // A new frame arriving before the final beat cannot be held anywhere.
        if (fft_valid_i && !capture_s) begin
          drop_s = 1'b1;
        end else begin
          drop_s = 1'b0;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State, captured frame, beat index and overrun pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cap_re_r  <= '0;
      cap_im_r  <= '0;
      sel_r     <= 2'd0;
      index_r   <= 5'd0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      overrun_r <= drop_s;
      if (capture_s) begin
        cap_re_r <= X_R_i;
        cap_im_r <= X_I_i;
        sel_r    <= fft_select_i;
        index_r  <= 5'd0;
      end else if (adv_s) begin
        index_r  <= index_r + 5'd1;
      end else begin
        index_r  <= index_r;
      end
    end
  end

  assign raw_re_s = cap_re_r[index_r*DW +: DW];
  assign raw_im_s = cap_im_r[index_r*DW +: DW];

`ifdef FFT_STREAM_SCALE_EN
  assign m_R_o = scale_fn(raw_re_s, sel_r);
  assign m_I_o = scale_fn(raw_im_s, sel_r);
`else
  assign m_R_o = raw_re_s;
  assign m_I_o = raw_im_s;
`endif

  assign m_valid_o = (state_r == STREAM);
  assign busy_o    = (state_r == STREAM);
  assign m_index_o = index_r;
  assign m_last_o  = (state_r == STREAM) && last_s;
  assign overrun_o = overrun_r;

endmodule
